// File: rtl/serial_receiver_pkg.sv
// Shared types and default constants for the CPLD UART receive path.
//   Bit_t / Byte_t  : scalar and byte-wide data types used on the CPLD pins
//   rx_state_t      : receive FSM state encoding
//   SERIAL_RX_*     : default FIFO depth and read-strobe width
package serial_receiver_pkg;

    typedef logic       Bit_t;
    typedef logic [7:0] Byte_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT_CLR
    } rx_state_t;

    localparam int unsigned SERIAL_RX_FIFO_DEPTH = 4;
    localparam int unsigned SERIAL_RX_RD_PULSE   = 2;

endpackage

// File: rtl/serial_rx_if.sv
// CPU-side receive bus of serial_receiver.
//   rx_valid  : FIFO not empty
//   rx_data   : FIFO head byte, valid while rx_valid
//   rx_pop    : consume the head byte (ignored when rx_valid is 0)
//   rx_count  : current number of FIFO entries
//   rx_full   : rx_count == FIFO_DEPTH
// master = receiver side, slave = CPU side.
interface serial_rx_if #(
    parameter int unsigned FIFO_DEPTH = serial_receiver_pkg::SERIAL_RX_FIFO_DEPTH
);
    import serial_receiver_pkg::*;

    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    Bit_t              rx_valid;
    Byte_t             rx_data;
    Bit_t              rx_pop;
    logic [CountW-1:0] rx_count;
    Bit_t              rx_full;

    modport master (
        output rx_valid,
        output rx_data,
        output rx_count,
        output rx_full,
        input  rx_pop
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  rx_count,
        input  rx_full,
        output rx_pop
    );

endinterface

// File: rtl/serial_rx_fifo.sv
// Registered circular-buffer FIFO for received bytes.
//   clk, rst  : clock, asynchronous active-high reset (clears storage too)
//   push      : write push_data at the tail
//   push_data : byte to store
//   pop       : drop the head entry (ignored when empty)
//   head      : storage word at the read pointer (combinational)
//   count     : number of stored entries
//   full      : count == DEPTH
//   empty     : count == 0
module serial_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PtrW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Receive side of the CPLD-hosted UART: waits for dataready, strobes uart_rdn low for
// RD_PULSE_CYCLES cycles, samples uart_data into a FIFO that the CPU pops.
//   clk, rst        : clock, asynchronous active-high reset
//   uart_rdn        : CPLD read strobe, active low (registered, reset to 1)
//   uart_dataready  : CPLD has a byte; asynchronous, synchronized here
//   uart_data       : CPLD data pins (sampled only)
//   tx_busy         : transmitter owns the data pins; blocks the start of a read
//   bus             : CPU-side receive bus (serial_rx_if master)
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = SERIAL_RX_FIFO_DEPTH,
    parameter int unsigned RD_PULSE_CYCLES = SERIAL_RX_RD_PULSE
) (
    input  Bit_t             clk,
    input  Bit_t             rst,
    output Bit_t             uart_rdn,
    input  Bit_t             uart_dataready,
    input  Byte_t            uart_data,
    input  Bit_t             tx_busy,
    serial_rx_if.master      bus
);
    localparam int unsigned CntW = $clog2(RD_PULSE_CYCLES + 1);

    logic [1:0]      sync_q;
    Bit_t            dr_s;
    rx_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    Bit_t            rdn_q, rdn_d;
    Bit_t            fifo_push;
    Bit_t            fifo_full;
    Bit_t            fifo_empty;

    assign dr_s     = sync_q[1];
    assign uart_rdn = rdn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            rdn_q   <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], uart_dataready};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdn_q   <= rdn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdn_d     = rdn_q;
        fifo_push = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A full FIFO leaves the byte in the CPLD rather than overrunning.
                if (dr_s && !tx_busy && !fifo_full) begin
                    rdn_d   = 1'b0;
                    cnt_d   = CntW'(RD_PULSE_CYCLES - 1);
                    state_d = READ;
                end
            end
            READ: begin
                // tx_busy is deliberately ignored here; the read always completes.
                if (cnt_q == '0) begin
                    fifo_push = 1'b1;
                    rdn_d     = 1'b1;
                    state_d   = WAIT_CLR;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            WAIT_CLR: begin
                // Wait for dataready to drop so one byte is never read twice.
                if (!dr_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                rdn_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    serial_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (uart_data),
        .pop       (bus.rx_pop),
        .head      (bus.rx_data),
        .count     (bus.rx_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.rx_valid = !fifo_empty;
    assign bus.rx_full  = fifo_full;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed, randomized-data bench for serial_receiver with a queue-based model of the FIFO.
module tb_serial_receiver;
    import serial_receiver_pkg::*;

    localparam int unsigned DEPTH = SERIAL_RX_FIFO_DEPTH;
    localparam int unsigned RD_P  = SERIAL_RX_RD_PULSE;

    logic       clk            = 1'b0;
    logic       rst            = 1'b1;
    logic       uart_rdn;
    logic       uart_dataready = 1'b0;
    logic [7:0] uart_data      = 8'h00;
    logic       tx_busy        = 1'b0;

    serial_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    serial_receiver #(
        .FIFO_DEPTH      (DEPTH),
        .RD_PULSE_CYCLES (RD_P)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_rdn       (uart_rdn),
        .uart_dataready (uart_dataready),
        .uart_data      (uart_data),
        .tx_busy        (tx_busy),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int errors    = 0;
    int checks    = 0;
    int pulses    = 0;
    int max_count = 0;
    logic [7:0] model_q[$];

    // Counts read strobes issued to the CPLD.
    always @(negedge uart_rdn) pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (int'(bus.rx_count) > max_count) max_count = int'(bus.rx_count);
    endtask

    task automatic start_byte(input logic [7:0] b);
        uart_data      = b;
        uart_dataready = 1'b1;
    endtask

    // Waits for a read strobe, measures its width and records the byte presented.
    task automatic wait_read(input string tag);
        bit         seen;
        int         n;
        logic [7:0] b;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (uart_rdn === 1'b0) seen = 1'b1;
        end
        check($sformatf("%s rdn_fell", tag), 32'(seen), 32'd1);
        if (seen) begin
            b = uart_data;
            n = 0;
            do begin
                step();
                n++;
            end while (uart_rdn === 1'b0 && n < 20);
            check($sformatf("%s rdn_low_cycles", tag), 32'(n), 32'(RD_P));
            model_q.push_back(b);
        end
    endtask

    task automatic settle();
        uart_dataready = 1'b0;
        repeat (4) step();
    endtask

    task automatic pop_check(input string tag);
        if (model_q.size() == 0) begin
            check($sformatf("%s valid_empty", tag), 32'(bus.rx_valid), 32'd0);
        end else begin
            check($sformatf("%s valid", tag), 32'(bus.rx_valid), 32'd1);
            check($sformatf("%s data", tag), 32'(bus.rx_data), 32'(model_q[0]));
            bus.rx_pop = 1'b1;
            step();
            bus.rx_pop = 1'b0;
            void'(model_q.pop_front());
            check($sformatf("%s count", tag), 32'(bus.rx_count), 32'(model_q.size()));
        end
    endtask

    initial begin
        int         p0;
        int         n;
        bit         seen;
        logic [7:0] b;

        bus.rx_pop = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset rdn", 32'(uart_rdn), 32'd1);
        check("reset valid", 32'(bus.rx_valid), 32'd0);
        check("reset data", 32'(bus.rx_data), 32'd0);
        check("reset count", 32'(bus.rx_count), 32'd0);
        check("reset full", 32'(bus.rx_full), 32'd0);
        repeat (2) step();

        // Single byte with exact latency: sampled at edge E, strobe low after E+2 for RD_P cycles
        start_byte(8'hA5);
        for (int k = 0; k <= int'(RD_P) + 2; k++) begin
            step();
            check($sformatf("single rdn k=%0d", k), 32'(uart_rdn),
                  (k >= 2 && k < int'(RD_P) + 2) ? 32'd0 : 32'd1);
            check($sformatf("single valid k=%0d", k), 32'(bus.rx_valid),
                  (k == int'(RD_P) + 2) ? 32'd1 : 32'd0);
        end
        model_q.push_back(8'hA5);
        check("single data", 32'(bus.rx_data), 32'hA5);
        settle();
        pop_check("single pop");
        check("single count0", 32'(bus.rx_count), 32'd0);

        // Fill and backpressure
        for (int i = 0; i < int'(DEPTH); i++) begin
            start_byte(8'($urandom));
            wait_read($sformatf("fill%0d", i));
            settle();
        end
        check("fill full", 32'(bus.rx_full), 32'd1);
        check("fill count", 32'(bus.rx_count), 32'(DEPTH));
        start_byte(8'($urandom));
        p0 = pulses;
        repeat (10) step();
        check("fill no_read_when_full", 32'(pulses - p0), 32'd0);
        check("fill rdn_idle", 32'(uart_rdn), 32'd1);
        pop_check("fill pop0");
        wait_read("fill last");
        settle();
        while (model_q.size() != 0) pop_check("fill drain");
        check("fill empty", 32'(bus.rx_valid), 32'd0);

        // Pointer wrap with one pop per push
        max_count = 0;
        for (int i = 0; i < 10; i++) begin
            start_byte(8'($urandom));
            wait_read($sformatf("wrap%0d", i));
            settle();
            pop_check($sformatf("wrap pop%0d", i));
        end
        check("wrap max_count", 32'(max_count <= 2), 32'd1);

        // tx_busy arbitration
        tx_busy = 1'b1;
        start_byte(8'($urandom));
        p0 = pulses;
        repeat (8) step();
        check("txbusy blocked", 32'(pulses - p0), 32'd0);
        tx_busy = 1'b0;
        step();
        check("txbusy release_fall", 32'(uart_rdn), 32'd0);
        b = uart_data;
        tx_busy = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (uart_rdn === 1'b0 && n < 20);
        check("txbusy pulse_completes", 32'(n), 32'(RD_P));
        model_q.push_back(b);
        tx_busy = 1'b0;
        settle();
        check("txbusy count", 32'(bus.rx_count), 32'(model_q.size()));
        pop_check("txbusy pop");

        // Sticky dataready yields one read
        start_byte(8'($urandom));
        p0 = pulses;
        wait_read("sticky");
        repeat (20) step();
        check("sticky pulses", 32'(pulses - p0), 32'd1);
        check("sticky count", 32'(bus.rx_count), 32'd1);
        settle();
        pop_check("sticky pop");

        // Reset during the read strobe
        start_byte(8'($urandom));
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (uart_rdn === 1'b0) seen = 1'b1;
        end
        check("rstmid strobe_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid rdn", 32'(uart_rdn), 32'd1);
        check("rstmid count", 32'(bus.rx_count), 32'd0);
        check("rstmid valid", 32'(bus.rx_valid), 32'd0);
        model_q.delete();
        step();
        step();
        rst = 1'b0;
        p0 = pulses;
        wait_read("rstmid reread");
        settle();
        check("rstmid one_pulse", 32'(pulses - p0), 32'd1);
        pop_check("rstmid pop");
        check("rstmid final_empty", 32'(bus.rx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Receive-side companion to `serial_controller` for the CPLD-hosted UART. It watches `uart_dataready`, runs the CPLD read strobe `uart_rdn`, and samples `uart_data`. Each captured byte goes into a small FIFO, and the CPU-side bus pops bytes from that FIFO. It shares the CPLD data pins with the transmitter and never starts a read while a write is in progress.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, at least 2.
- `RD_PULSE_CYCLES`, 2: number of cycles `uart_rdn` is held low before sampling; at least 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `uart_rdn` out 1: CPLD read strobe, active low.
- `uart_dataready` in 1: CPLD has a received byte; asynchronous to `clk`.
- `uart_data` in 8 (`Byte_t`): CPLD data pins. The top level owns the tri-state; this block only samples.
- `tx_busy` in 1: transmitter is using the data pins (`uart_wrn` low or a write pending).
- `rx_valid` out 1: FIFO not empty.
- `rx_data` out 8: FIFO head byte; valid while `rx_valid`.
- `rx_pop` in 1: consume the head byte. Ignored when `rx_valid` is 0.
- `rx_count` out $clog2(FIFO_DEPTH)+1: current number of FIFO entries.
- `rx_full` out 1: `rx_count == FIFO_DEPTH`.

## Operation
- `uart_dataready` passes through a 2-flop synchronizer; the synchronized signal is `dr_s`. No other input is synchronized.
- FSM, state type `rx_state_t`:
  - `IDLE`: if `dr_s && !tx_busy && !rx_full`, drive `uart_rdn` to 0, load `cnt = RD_PULSE_CYCLES-1`, go to `READ`. Otherwise stay, with `uart_rdn` at 1.
  - `READ`: `uart_rdn` stays 0 and `cnt` decrements. When `cnt == 0`:
    - push `uart_data` into the FIFO;
    - drive `uart_rdn` to 1;
    - go to `WAIT_CLR`.
  - `WAIT_CLR`: `uart_rdn` is 1. Go to `IDLE` when `dr_s == 0`, so the same byte is never read twice.
- Full FIFO: the block does not read. The byte stays in the CPLD, so there is no overrun and no data loss.
- `tx_busy` is only checked in `IDLE`. Once `READ` starts it runs to completion; the transmitter must wait for `uart_rdn == 1` (the top level ANDs the two grants).
- FIFO: a registered circular buffer.
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo `FIFO_DEPTH`.
  - `rx_data` is `mem[rd_ptr]`, read combinationally from the storage registers.
  - Push and pop in the same cycle: both happen, and `rx_count` is unchanged. When the FIFO is full, such a push is legal because the push is gated only in `IDLE`; a push arriving in `READ` always has space reserved.

## Timing
- Reset values:
  - `uart_rdn` = 1; `rx_valid` = 0; `rx_data` = 0 (storage cleared); `rx_count` = 0; `rx_full` = 0.
  - FSM in `IDLE`; pointers 0; synchronizer flops 0.
- Reset asserted mid-`READ`: `uart_rdn` goes to 1 immediately (asynchronous) and the partial byte is discarded. The CPLD re-presents the byte on the next `dataready`.
- Latency, with `uart_dataready` sampled high at edge E:
  - `dr_s` is high after E+1.
  - `uart_rdn` falls after E+2.
  - `uart_rdn` stays low for exactly `RD_PULSE_CYCLES` cycles.
  - The byte is sampled and `uart_rdn` rises at edge E+2+`RD_PULSE_CYCLES`.
  - `rx_valid` and `rx_data` are updated after that same edge.
- Minimum spacing between reads:
  - `RD_PULSE_CYCLES` + 1 (`WAIT_CLR`) + 1 (`IDLE`) cycles;
  - plus the synchronizer delay of `dataready` falling, which is 2 cycles.
- `rx_pop` takes effect at the clock edge where it is sampled with `rx_valid` = 1. The new head is visible the following cycle.

## Structure
- Shared package (`defines.svh`): `Bit_t`, `Byte_t` (existing); `rx_state_t` enum {`IDLE`, `READ`, `WAIT_CLR`}; default constants `SERIAL_RX_FIFO_DEPTH` = 4 and `SERIAL_RX_RD_PULSE` = 2.
- Sub-module `serial_rx_fifo`:
  - parameters `DEPTH`, `WIDTH`;
  - ports `clk`, `rst`, `push`, `push_data`, `pop`, `head`, `count`, `full`, `empty`.
- Synchronizer and FSM are inline in `serial_receiver`.

## Test plan
- Single byte: reset, drive `uart_data` = 0xA5, raise `dataready` at edge 10 → `uart_rdn` low during cycles 12–13 (`RD_PULSE_CYCLES` = 2), rises at edge 14; `rx_valid` = 1, `rx_data` = 0xA5; drop `dataready`, pulse `rx_pop` → `rx_valid` = 0, `rx_count` = 0.
- Fill/backpressure: present 0x01..0x05 with no pops → 4 `uart_rdn` pulses, `rx_full` = 1, `uart_rdn` stays 1 while the 5th byte waits. One `rx_pop` → 5th read happens; pops then return 0x02, 0x03, 0x04, 0x05 in order.
- Pointer wrap: 10 bytes 0x10..0x19 interleaved with pops, one pop per push → all popped in order, `rx_count` never exceeds 2.
- `tx_busy` arbitration: hold `tx_busy` = 1 and raise `dataready` → no `uart_rdn` pulse. Release `tx_busy` → `uart_rdn` falls 1 cycle later. Raise `tx_busy` during `READ` → the pulse still completes.
- Sticky `dataready`: hold `dataready` high for 20 cycles after one read → exactly one `uart_rdn` pulse and `rx_count` = 1.
- Reset mid-read: assert `rst` while `uart_rdn` = 0 → `uart_rdn` = 1 in the same cycle, `rx_count` = 0. After release, with `dataready` still high → one clean read of the byte.
